// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 FIFO drain sequencer and scan-code event parser
//
// Pops bytes from the ps2_keyboard FIFO with a one-cycle active-low strobe,
// strips E0/F0 prefixes and emits single-cycle key events with typematic
// detection, a BCD new-press counter, a held-key register and a sticky
// overflow flag.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   ready, data         FIFO non-empty and head byte
//   overflow            FIFO overflow level
//   nextdata_n          FIFO pop strobe, active-low, registered
//   key_valid           one-cycle event pulse; key_code/ext/break/repeat hold
//   key_down            a key is currently held
//   held_code, held_ext the held key
//   cnt_tens, cnt_ones  BCD count of new presses, 00-99
//   ovf_flag            sticky overflow indicator
module ps2_key_ctrl #(
    parameter int GUARD   = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] data,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_repeat,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       ovf_flag
);
    localparam int GW = $clog2(GUARD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, POP, GUARD_WAIT} state_t;

    state_t          state, state_nx;
    logic            nd_nx;
    logic [GW-1:0]   guard_cnt, guard_nx;
    logic [7:0]      byte_reg;
    logic            ext_pend, brk_pend, ovf_prev;
    logic [TW-1:0]   tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            nextdata_n <= 1'b1;
            guard_cnt  <= '0;
        end else begin
            state      <= state_nx;
            nextdata_n <= nd_nx;
            guard_cnt  <= guard_nx;
        end
    end

    // nd_nx is the value nextdata_n takes next cycle, so it is low only
    // for the single cycle spent in POP.
    always_comb begin
        state_nx = state;
        nd_nx    = 1'b1;
        guard_nx = guard_cnt;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_nx = POP;
                    nd_nx    = 1'b0;
                end
            end
            POP: begin
                state_nx = GUARD_WAIT;
                guard_nx = GW'(GUARD);
            end
            GUARD_WAIT: begin
                guard_nx = guard_cnt - 1'b1;
                if (guard_cnt == GW'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    logic pop, ovf_rise, ext_eff, brk_eff, is_e0, is_f0, hit, tmo_hit;

    // An overflow edge in the POP cycle resynchronises the stream before
    // the popped byte is interpreted, hence the masked prefix flags.
    always_comb begin
        pop      = (state == POP);
        ovf_rise = overflow & ~ovf_prev;
        ext_eff  = ext_pend & ~ovf_rise;
        brk_eff  = brk_pend & ~ovf_rise;
        is_e0    = (byte_reg == 8'hE0);
        is_f0    = (byte_reg == 8'hF0);
        hit      = ({held_ext, held_code} == {ext_eff, byte_reg});
        tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_reg   <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            ovf_prev   <= 1'b0;
            ovf_flag   <= 1'b0;
            tmo_cnt    <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_ext    <= 1'b0;
            key_break  <= 1'b0;
            key_repeat <= 1'b0;
            key_down   <= 1'b0;
            held_code  <= '0;
            held_ext   <= 1'b0;
            cnt_tens   <= '0;
            cnt_ones   <= '0;
        end else begin
            ovf_prev  <= overflow;
            key_valid <= 1'b0;
            if (ovf_rise) ovf_flag <= 1'b1;
            if (state == IDLE && ready) byte_reg <= data;

            // A pop takes priority over the prefix timeout.
            if (pop) begin
                tmo_cnt <= '0;
                if (is_e0) begin
                    ext_pend <= 1'b1;
                    brk_pend <= brk_eff;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                    ext_pend <= ext_eff;
                end else begin
                    ext_pend   <= 1'b0;
                    brk_pend   <= 1'b0;
                    key_valid  <= 1'b1;
                    key_code   <= byte_reg;
                    key_ext    <= ext_eff;
                    key_break  <= brk_eff;
                    key_repeat <= 1'b0;
                    if (!brk_eff) begin
                        if (key_down && hit) begin
                            key_repeat <= 1'b1;
                        end else begin
                            held_code <= byte_reg;
                            held_ext  <= ext_eff;
                            key_down  <= 1'b1;
                            if (cnt_ones == 4'd9) begin
                                cnt_ones <= 4'd0;
                                cnt_tens <= (cnt_tens == 4'd9) ? 4'd0 : cnt_tens + 4'd1;
                            end else begin
                                cnt_ones <= cnt_ones + 4'd1;
                            end
                        end
                    end else if (hit) begin
                        key_down <= 1'b0;
                    end
                end
            end else if (ovf_rise) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
                tmo_cnt  <= '0;
            end else if (ext_pend || brk_pend) begin
                if (tmo_hit) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencing controller between the ps2_keyboard receive FIFO and display/application logic. It drains the FIFO with a clean one-cycle nextdata_n pop handshake and parses the byte stream (E0 extended prefix, F0 break prefix, typematic repeats) into single-cycle key events. It also maintains a BCD press counter (00-99), a held-key register and a sticky FIFO-overflow flag. Display top levels consume its outputs instead of reading the FIFO directly.

Parameters:
GUARD, 1, idle cycles after each pop before ready is sampled again (min 1; covers the FIFO pointer update)
TIMEOUT, 65535, clk cycles a dangling E0/F0 prefix may wait for its code byte before being discarded

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
ready  in  1  FIFO non-empty, from ps2_keyboard
data  in  8  FIFO head byte, valid while ready=1
overflow  in  1  FIFO overflow, from ps2_keyboard
nextdata_n  out  1  FIFO pop strobe, active-low, registered
key_valid  out  1  one-cycle pulse: key event fields valid
key_code  out  8  scan code of the event (prefixes stripped)
key_ext  out  1  event was E0-prefixed
key_break  out  1  event is a release (F0-prefixed)
key_repeat  out  1  make event identical to currently held key (typematic)
key_down  out  1  a key is currently held
held_code  out  8  code of the held key (held_ext in bit-parallel register below)
held_ext  out  1  held key is extended
cnt_tens  out  4  BCD tens of new-press count
cnt_ones  out  4  BCD ones of new-press count
ovf_flag  out  1  sticky overflow indicator

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_break=0; key_repeat=0; key_down=0; held_code=0; held_ext=0; cnt=00; ovf_flag=0; prefix flags cleared; timeout counter=0. Reset mid-pop forces nextdata_n=1 on that same edge.
- FSM states: IDLE, POP, GUARD_WAIT.
  - IDLE: if ready=1, latch data into byte register, drive nextdata_n=0 next cycle, go POP. Otherwise stay.
  - POP: nextdata_n=0 for exactly this one cycle. Byte is parsed. Go to GUARD_WAIT, which loads the guard counter with GUARD.
  - GUARD_WAIT: nextdata_n=1. Count down and return to IDLE when the count reaches 0.
  - Throughput: one byte per 2+GUARD cycles (3 at default). nextdata_n is never low for 2 consecutive cycles.
- Parse, performed in the POP cycle; outputs are registered, so key_valid appears on the cycle after POP:
  - E0: set ext_pend. No event.
  - F0: set brk_pend. No event.
  - Any other byte: key_valid=1 for 1 cycle. key_code=byte, key_ext=ext_pend, key_break=brk_pend. Then clear both pending flags.
- Make event (brk_pend=0):
  - If key_down=1 and {held_ext,held_code}=={ext,code}: key_repeat=1, counter unchanged.
  - Otherwise: key_repeat=0, held<= {ext,code}, key_down=1, counter +1.
- Break event:
  - If {ext,code} equals the held key: key_down=0. held_code/held_ext keep their values.
  - Break of a non-held key: event is emitted, held state is unchanged.
  - key_repeat is 0 on all break events.
- Counter: BCD. Ones increments 0-9; on 9 it wraps to 0 and carries into tens. 99 wraps to 00.
- Prefix timeout: while either pending flag is set, count clk cycles. On reaching TIMEOUT, clear both flags and emit no event. The counter resets whenever a byte is popped.
- Overflow: a rising edge of overflow sets ovf_flag, which stays set until reset. The same edge clears the pending prefix flags (stream is resynchronised). Draining continues normally.
- Simultaneous: a timeout expiring in the same cycle as a POP is ignored; the popped byte is parsed with the flags intact. An overflow edge coinciding with a POP clears the flags before the byte is parsed.
- Outputs are fully registered. All key_* fields hold their value until the next event; only key_valid pulses.

Test Plan:
- Reset/idle: rst=0 for 2 cycles with ready=1 -> nextdata_n=1, cnt=00, key_down=0, ovf_flag=0. Release with ready=0 -> no pops.
- Make/break: FIFO bytes 1C, F0, 1C -> exactly 3 single-cycle nextdata_n lows, each ≥3 cycles apart. Two key_valid pulses: (1C, ext0, brk0, rep0) then (1C, brk1). key_down goes 1 then 0. cnt=01.
- Typematic: 1C,1C,1C,F0,1C -> three make events with key_repeat=0,1,1. cnt=01. Final key_down=0.
- Extended key: E0,75,E0,F0,75 -> make(75, ext1) and break(75, ext1). held_ext=1 while held. cnt=01. Plain 75 while E0-75 is held -> new press, cnt=02.
- Counter wrap: 100 distinct make/break pairs (alternating 1C/32) -> cnt progresses 09->10 and 99->00. Final cnt=00.
- Prefix timeout and overflow: E0, then idle TIMEOUT cycles, then 1C -> event ext=0. Pulse overflow during F0 pending, then 1C -> ovf_flag=1 and event break=0 (make).
